// File: rtl/fc_layer_sequencer.sv
// Sequences one INT8 fully connected layer: stages in/weights/bias from a byte memory, fires the datapath, streams results.
// Optional weight reuse (keep_w port, segment-2 skip) is built when FC_SEQ_WREUSE_EN is defined.
module fc_layer_sequencer #(
    parameter int INPUT_SIZE  = 128,
    parameter int OUTPUT_SIZE = 10,
    parameter int ADDR_W      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [ADDR_W-1:0]                   in_base,
    input  logic [ADDR_W-1:0]                   w_base,
    input  logic [ADDR_W-1:0]                   b_base,
`ifdef FC_SEQ_WREUSE_EN
    input  logic                                keep_w,
`endif
    output logic                                busy,
    output logic                                done,
    output logic                                mem_rd_en,
    output logic [ADDR_W-1:0]                   mem_addr,
    input  logic                                mem_gnt,
    input  logic [7:0]                          mem_rdata,
    output logic [INPUT_SIZE*8-1:0]             fc_in_vec,
    output logic [OUTPUT_SIZE*INPUT_SIZE*8-1:0] fc_weights,
    output logic [OUTPUT_SIZE*8-1:0]            fc_bias,
    output logic                                fc_en,
    input  logic [OUTPUT_SIZE*8-1:0]            fc_out_vec,
    input  logic                                fc_valid,
    output logic [7:0]                          out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic [2:0]                          dbg_state
);

    localparam int W_BYTES = OUTPUT_SIZE * INPUT_SIZE;
    localparam int R_TOTAL = INPUT_SIZE + W_BYTES + OUTPUT_SIZE;
    localparam int KW      = $clog2(R_TOTAL + 1);
    localparam int NW      = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

    localparam logic [KW-1:0] K_END    = KW'(R_TOTAL);
    localparam logic [KW-1:0] K_W0     = KW'(INPUT_SIZE);
    localparam logic [KW-1:0] K_B0     = KW'(INPUT_SIZE + W_BYTES);
    localparam logic [KW-1:0] K_IN_END = KW'(INPUT_SIZE - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(OUTPUT_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FIRE  = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic              pend_q, pend_d;
    logic [KW-1:0]     pend_k_q, pend_k_d;
    logic [NW-1:0]     n_q, n_d;
    logic [ADDR_W-1:0] in_base_q, w_base_q, b_base_q;
    logic              start_acc;
    logic              cap_res;
    logic              skip_w;
    logic [ADDR_W-1:0] rd_addr;

    logic [7:0] in_q  [INPUT_SIZE];
    logic [7:0] w_q   [W_BYTES];
    logic [7:0] b_q   [OUTPUT_SIZE];
    logic [7:0] res_q [OUTPUT_SIZE];

    assign start_acc = (state_q == S_IDLE) && start;
    assign dbg_state = state_q;

`ifdef FC_SEQ_WREUSE_EN
    logic keep_w_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            keep_w_q <= 1'b0;
        else if (start_acc) keep_w_q <= keep_w;
    end
    assign skip_w = keep_w_q;
`else
    assign skip_w = 1'b0;
`endif

    // Linear read index k maps onto three address segments.
    always_comb begin
        rd_addr = '0;
        if (k_q < K_W0)      rd_addr = in_base_q + ADDR_W'(k_q);
        else if (k_q < K_B0) rd_addr = w_base_q + ADDR_W'(k_q - K_W0);
        else                 rd_addr = b_base_q + ADDR_W'(k_q - K_B0);
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pend_d    = 1'b0;
        pend_k_d  = pend_k_q;
        n_d       = n_q;
        cap_res   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        fc_en     = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                    k_d     = '0;
                    n_d     = '0;
                end
            end
            S_LOAD: begin
                if (k_q != K_END) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = rd_addr;
                    if (mem_gnt) begin
                        pend_d   = 1'b1;
                        pend_k_d = k_q;
                        k_d      = (skip_w && k_q == K_IN_END) ? K_B0 : k_q + KW'(1);
                    end
                end else begin
                    // The final byte is being written this cycle.
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                fc_en   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fc_valid) begin
                    cap_res = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (n_q == N_LAST);
                for (int o = 0; o < OUTPUT_SIZE; o++) begin
                    if (n_q == NW'(o)) out_data = res_q[o];
                end
                if (out_ready) begin
                    if (n_q == N_LAST) state_d = S_DONE;
                    else               n_d = n_q + NW'(1);
                end
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            pend_q    <= 1'b0;
            pend_k_q  <= '0;
            n_q       <= '0;
            in_base_q <= '0;
            w_base_q  <= '0;
            b_base_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            pend_q   <= pend_d;
            pend_k_q <= pend_k_d;
            n_q      <= n_d;
            if (start_acc) begin
                in_base_q <= in_base;
                w_base_q  <= w_base;
                b_base_q  <= b_base;
            end
        end
    end

    // Staging bytes are written one cycle after their read is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < INPUT_SIZE; j++)  in_q[j]  <= '0;
            for (int j = 0; j < W_BYTES; j++)     w_q[j]   <= '0;
            for (int o = 0; o < OUTPUT_SIZE; o++) b_q[o]   <= '0;
            for (int o = 0; o < OUTPUT_SIZE; o++) res_q[o] <= '0;
        end else begin
            if (pend_q) begin
                for (int j = 0; j < INPUT_SIZE; j++)
                    if (pend_k_q == KW'(j)) in_q[j] <= mem_rdata;
                for (int j = 0; j < W_BYTES; j++)
                    if (pend_k_q == KW'(INPUT_SIZE + j)) w_q[j] <= mem_rdata;
                for (int o = 0; o < OUTPUT_SIZE; o++)
                    if (pend_k_q == KW'(INPUT_SIZE + W_BYTES + o)) b_q[o] <= mem_rdata;
            end
            if (cap_res) begin
                for (int o = 0; o < OUTPUT_SIZE; o++) res_q[o] <= fc_out_vec[o*8 +: 8];
            end
        end
    end

    for (genvar j = 0; j < INPUT_SIZE; j++) begin : g_in
        assign fc_in_vec[j*8 +: 8] = in_q[j];
    end
    for (genvar j = 0; j < W_BYTES; j++) begin : g_w
        assign fc_weights[j*8 +: 8] = w_q[j];
    end
    for (genvar o = 0; o < OUTPUT_SIZE; o++) begin : g_b
        assign fc_bias[o*8 +: 8] = b_q[o];
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer (INPUT_SIZE=4, OUTPUT_SIZE=2): memory and datapath models, scoreboarded stream and reads.
// Define FC_SEQ_WREUSE_EN for both files to exercise weight reuse.
module tb_fc_layer_sequencer;

    localparam int IN  = 4;
    localparam int OUT = 2;
    localparam logic [15:0] IN_BASE = 16'h0100;
    localparam logic [15:0] W_BASE  = 16'hFFFE;
    localparam logic [15:0] B_BASE  = 16'h0200;
    localparam logic [31:0] IV1 = 32'h04030201;
    localparam logic [63:0] WV1 = 64'h000000FF_01010101;
    localparam logic [15:0] BV1 = 16'hFB0A;

    logic              clk, rst, start;
    logic [15:0]       in_base, w_base, b_base;
    logic              busy, done, mem_rd_en, mem_gnt, fc_en, fc_valid;
    logic [15:0]       mem_addr;
    logic [7:0]        mem_rdata, out_data;
    logic [IN*8-1:0]   fc_in_vec;
    logic [OUT*IN*8-1:0] fc_weights;
    logic [OUT*8-1:0]  fc_bias, fc_out_vec;
    logic              out_valid, out_ready, out_last;
    logic [2:0]        dbg_state;
`ifdef FC_SEQ_WREUSE_EN
    logic              keep_w;
`endif

    fc_layer_sequencer #(.INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_base(in_base), .w_base(w_base), .b_base(b_base),
`ifdef FC_SEQ_WREUSE_EN
        .keep_w(keep_w),
`endif
        .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .fc_in_vec(fc_in_vec), .fc_weights(fc_weights), .fc_bias(fc_bias), .fc_en(fc_en),
        .fc_out_vec(fc_out_vec), .fc_valid(fc_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle driver ----------------
    int cyc = 0, base = 0, rel = 0;
    logic go = 1'b0, rst_force = 1'b1, gnt_toggle = 1'b0;
    int rst_rel = -1, pa = -1, pb = -1, hlo = -1, hhi = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rst = 1'b1; start = 1'b0; mem_gnt = 1'b1; out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (go) begin
                base  = cyc;
                go    = 1'b0;
                rel   = 0;
                start = 1'b1;
            end else begin
                rel   = cyc - base;
                start = (rel == pa) || (rel == pb);
            end
            mem_gnt   = gnt_toggle ? (rel % 2 == 0) : 1'b1;
            out_ready = !(rel >= hlo && rel <= hhi);
            rst       = rst_force || (rel == rst_rel);
        end
    end

    // ---------------- memory and datapath models ----------------
    logic [7:0] mem [1024];

    always @(posedge clk) begin
        if (mem_rd_en && mem_gnt) mem_rdata <= mem[mem_addr[9:0]];
        else                      mem_rdata <= 8'($urandom);
    end

    function automatic logic [OUT*8-1:0] dp(logic [IN*8-1:0] iv, logic [OUT*IN*8-1:0] w,
                                            logic [OUT*8-1:0] b);
        logic [OUT*8-1:0] r;
        logic signed [7:0] x, y;
        int acc;
        r = '0;
        for (int o = 0; o < OUT; o++) begin
            x = b[o*8 +: 8];
            acc = int'(x);
            for (int i = 0; i < IN; i++) begin
                x = iv[i*8 +: 8];
                y = w[(o*IN+i)*8 +: 8];
                acc += int'(x) * int'(y);
            end
            if (acc > 127) acc = 127;
            if (acc < -128) acc = -128;
            r[o*8 +: 8] = 8'(acc);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        fc_valid <= fc_en;
        if (fc_en) fc_out_vec <= dp(fc_in_vec, fc_weights, fc_bias);
    end

    // ---------------- scoreboard ----------------
    logic [8:0]  exp_q[$];
    logic [15:0] exp_addr_q[$];
    int n_cmp = 0, n_bad = 0;
    int read_cnt, fen_rel, done_cnt, done_rel, last_beat_rel;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic        held_v = 1'b0, stall_v = 1'b0;
    logic [15:0] held_addr;
    logic [8:0]  stall_beat;

    always @(negedge clk) begin
        int r;
        r = cyc - base;
        if (rst) begin
            check("reset_outputs",
                  {busy, done, mem_rd_en, mem_addr, fc_en, out_valid, out_last, out_data,
                   |fc_in_vec, |fc_weights, |fc_bias, dbg_state}, 64'd0);
            held_v  = 1'b0;
            stall_v = 1'b0;
        end else begin
            if (held_v && mem_rd_en) check("addr_hold", mem_addr, held_addr);
            held_v = 1'b0;
            if (mem_rd_en && mem_gnt) begin
                read_cnt++;
                if (exp_addr_q.size() == 0) check("addr_extra", 64'd1, 64'd0);
                else                        check("read_addr", mem_addr, exp_addr_q.pop_front());
            end else if (mem_rd_en) begin
                held_v    = 1'b1;
                held_addr = mem_addr;
            end
            if (fc_en) fen_rel = r;
            if (done) begin
                done_cnt++;
                done_rel = r;
            end
            if (stall_v && out_valid) check("stall_stable", {out_last, out_data}, stall_beat);
            stall_v = 1'b0;
            if (out_valid && out_ready) begin
                last_beat_rel = r;
                if (exp_q.size() == 0) check("beat_extra", 64'd1, 64'd0);
                else                   check("out_beat", {out_last, out_data}, exp_q.pop_front());
            end else if (out_valid) begin
                stall_v    = 1'b1;
                stall_beat = {out_last, out_data};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_mem(input logic [31:0] iv, input logic [63:0] w, input logic [15:0] b);
        logic [15:0] a;
        for (int j = 0; j < IN; j++) begin
            a = IN_BASE + 16'(j);
            mem[a[9:0]] = iv[j*8 +: 8];
        end
        for (int j = 0; j < OUT*IN; j++) begin
            a = W_BASE + 16'(j);
            mem[a[9:0]] = w[j*8 +: 8];
        end
        for (int o = 0; o < OUT; o++) begin
            a = B_BASE + 16'(o);
            mem[a[9:0]] = b[o*8 +: 8];
        end
    endtask

    task automatic push_reads(input logic skip_w);
        for (int j = 0; j < IN; j++) exp_addr_q.push_back(IN_BASE + 16'(j));
        if (!skip_w)
            for (int j = 0; j < OUT*IN; j++) exp_addr_q.push_back(W_BASE + 16'(j));
        for (int o = 0; o < OUT; o++) exp_addr_q.push_back(B_BASE + 16'(o));
    endtask

    task automatic push_out(input logic [7:0] d0, input logic [7:0] d1);
        exp_q.push_back({1'b0, d0});
        exp_q.push_back({1'b1, d1});
    endtask

    task automatic launch();
        read_cnt = 0; fen_rel = -1; done_cnt = 0; done_rel = -1; last_beat_rel = -1;
        @(negedge clk);
        go = 1'b1;
    endtask

    task automatic run_and_wait(input int budget);
        int i;
        launch();
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("done_after_last", done_rel, last_beat_rel + 1);
        check("busy_idle", {busy, out_valid, mem_rd_en}, 0);
        check("exp_q_drained", exp_q.size(), 0);
        check("addr_q_drained", exp_addr_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        in_base = IN_BASE; w_base = W_BASE; b_base = B_BASE;
`ifdef FC_SEQ_WREUSE_EN
        keep_w = 1'b0;
`endif
        for (int j = 0; j < 1024; j++) mem[j] = 8'($urandom_range(0, 255));
        repeat (3) @(negedge clk);
        rst_force = 1'b0;
        @(negedge clk);
        check("reset_state", {busy, done, fc_en, out_valid, dbg_state, fc_bias}, 0);

        // Basic run: 14 reads, fc_en at 16, outputs 20 and -6.
        set_mem(IV1, WV1, BV1);
        push_reads(1'b0);
        push_out(8'h14, 8'hFA);
        run_and_wait(200);
        check("t1_reads", read_cnt, 14);
        check("t1_fc_en_cycle", fen_rel, 16);
        check("t1_in_vec", fc_in_vec, IV1);
        check("t1_weights", fc_weights, WV1);
        check("t1_bias", fc_bias, BV1);

        // Grant toggling: addresses hold on gnt=0, fc_en at 30.
        gnt_toggle = 1'b1;
        push_reads(1'b0);
        push_out(8'h14, 8'hFA);
        run_and_wait(200);
        gnt_toggle = 1'b0;
        check("t2_reads", read_cnt, 14);
        check("t2_fc_en_cycle", fen_rel, 30);
        check("t2_weights", fc_weights, WV1);

        // Saturated results passed through; ready low 3 cycles after first beat.
        set_mem(32'h7F7F7F7F, 64'h7F7F7F7F_7F7F7F7F, 16'h807F);
        push_reads(1'b0);
        push_out(8'h7F, 8'h7F);
        hlo = 19; hhi = 21;
        run_and_wait(200);
        hlo = -1; hhi = -1;
        check("t3_last_beat_cycle", last_beat_rel, 22);

        // Start pulsed during LOAD and in the done cycle: ignored.
        set_mem(IV1, WV1, BV1);
        push_reads(1'b0);
        push_out(8'h14, 8'hFA);
        pa = 5; pb = 20;
        run_and_wait(200);
        check("t4_done_cycle", done_rel, 20);
        repeat (20) @(negedge clk);
        pa = -1; pb = -1;
        check("t4_single_run", {read_cnt[15:0], done_cnt[15:0], 15'd0, busy}, {16'd14, 16'd1, 16'd0});

        // Reset during LOAD (cycle 7): abort, no done.
        push_reads(1'b0);
        rst_rel = 7;
        launch();
        repeat (30) @(negedge clk);
        rst_rel = -1;
        check("t5a_no_done", done_cnt, 0);
        check("t5a_reads_before_rst", read_cnt, 6);
        exp_addr_q.delete();
        exp_q.delete();
        push_reads(1'b0);
        push_out(8'h14, 8'hFA);
        run_and_wait(200);
        check("t5a_fresh_in_vec", fc_in_vec, IV1);

        // Reset during DRAIN with the stream stalled.
        push_reads(1'b0);
        push_out(8'h14, 8'hFA);
        hlo = 18; hhi = 100000; rst_rel = 21;
        launch();
        repeat (30) @(negedge clk);
        rst_rel = -1; hlo = -1; hhi = -1;
        check("t5b_no_done", done_cnt, 0);
        check("t5b_unsent", exp_q.size(), 2);
        exp_q.delete();
        exp_addr_q.delete();
        push_reads(1'b0);
        push_out(8'h14, 8'hFA);
        run_and_wait(200);

`ifdef FC_SEQ_WREUSE_EN
        // Weight reuse: second run skips weights, outputs 18 and -7.
        keep_w = 1'b0;
        push_reads(1'b0);
        push_out(8'h14, 8'hFA);
        run_and_wait(200);
        set_mem(32'h02020202, 64'd0, BV1);
        keep_w = 1'b1;
        push_reads(1'b1);
        push_out(8'h12, 8'hF9);
        run_and_wait(200);
        keep_w = 1'b0;
        check("wr_reads", read_cnt, 6);
        check("wr_weights_kept", fc_weights, WV1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
